// File: rtl/ahblite_led_ctrl_if.sv
// AHB-Lite slave-side bus bundle for the LED controller.
// The master modport is the bus-matrix view used by whoever drives the slave.
interface ahblite_led_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahblite_led_ctrl.sv
// Zero-wait-state AHB-Lite LED controller: static, PWM, rotate and blink modes,
// all paced by a programmable prescaler tick.
module ahblite_led_ctrl #(
    parameter int unsigned NUM_LED      = 8,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned PRE_BITS     = 16,
    parameter logic [31:0] RST_PRESCALE = 32'd999
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahblite_led_ctrl_if.slave    bus,
    output logic [NUM_LED-1:0]   LED
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_PWM    = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PATTERN  = 3'd1;
    localparam logic [2:0] A_PRESCALE = 3'd2;
    localparam logic [2:0] A_DUTY     = 3'd3;
    localparam logic [2:0] A_STATUS   = 3'd4;

    localparam logic [PRE_BITS-1:0] RST_PRE = RST_PRESCALE[PRE_BITS-1:0];

    // bus pipeline
    logic [2:0]          r_addr_q;
    logic                r_wr_q;
    // programmable registers
    logic                r_en;
    mode_e               r_mode;
    logic [NUM_LED-1:0]  r_pattern;
    logic [PRE_BITS-1:0] r_prescale;
    logic [PWM_BITS-1:0] r_duty;
    // timebase
    logic [PRE_BITS-1:0] r_pre_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_phase;
    logic [NUM_LED-1:0]  r_led;

    logic                w_addr_ph;
    logic                w_we;
    logic                w_wr_ctrl;
    logic                w_wr_pattern;
    logic                w_wr_pre;
    logic                w_wr_duty;
    logic                w_tick;
    logic                w_wrap;
    logic                w_gate;
    logic                w_on;
    logic [NUM_LED-1:0]  w_rot;
    logic [31:0]         w_status;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_addr_ph    = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign w_we         = r_wr_q & bus.HREADY;
    assign w_wr_ctrl    = w_we & (r_addr_q == A_CTRL);
    assign w_wr_pattern = w_we & (r_addr_q == A_PATTERN);
    assign w_wr_pre     = w_we & (r_addr_q == A_PRESCALE);
    assign w_wr_duty    = w_we & (r_addr_q == A_DUTY);

    assign w_tick = (r_pre_cnt == r_prescale);
    assign w_wrap = w_tick & (&r_pwm_cnt);
    assign w_rot  = (r_pattern << 1) | (r_pattern >> (NUM_LED - 1));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_addr_q <= 3'd0;
            r_wr_q   <= 1'b0;
        end else if (w_addr_ph) begin
            r_addr_q <= bus.HADDR[4:2];
            r_wr_q   <= bus.HWRITE;
        end else begin
            r_wr_q   <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_en       <= 1'b0;
            r_mode     <= MODE_STATIC;
            r_prescale <= RST_PRE;
            r_duty     <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en   <= bus.HWDATA[0];
                r_mode <= mode_e'(bus.HWDATA[2:1]);
            end
            if (w_wr_pre)
                r_prescale <= bus.HWDATA[PRE_BITS-1:0];
            if (w_wr_duty)
                r_duty <= bus.HWDATA[PWM_BITS-1:0];
        end
    end

    // A bus write to PATTERN overrides the rotation that would land on the same edge.
    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            r_pattern <= '0;
        else if (w_wr_pattern)
            r_pattern <= bus.HWDATA[NUM_LED-1:0];
        else if (w_wrap && r_mode == MODE_ROTATE)
            r_pattern <= w_rot;
    end

    // CTRL writes restart the whole timebase so a new mode starts from a clean period.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
            r_phase   <= 1'b0;
        end else begin
            if (w_wr_ctrl || w_wr_pre || w_tick)
                r_pre_cnt <= '0;
            else
                r_pre_cnt <= r_pre_cnt + PRE_BITS'(1);

            if (w_wr_ctrl)
                r_pwm_cnt <= '0;
            else if (w_tick)
                r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);

            if (w_wr_ctrl)
                r_phase <= 1'b0;
            else if (w_wrap && r_mode == MODE_BLINK)
                r_phase <= ~r_phase;
        end
    end

    always_comb begin
        w_gate = 1'b0;
        unique case (r_mode)
            MODE_STATIC: w_gate = 1'b1;
            MODE_PWM:    w_gate = (r_pwm_cnt < r_duty);
            MODE_ROTATE: w_gate = 1'b1;
            MODE_BLINK:  w_gate = r_phase;
        endcase
    end

    assign w_on = r_en & w_gate;

    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            r_led <= '0;
        else
            r_led <= w_on ? r_pattern : '0;
    end

    assign LED = r_led;

    assign w_status = 32'(r_led) | {15'd0, r_phase, 16'd0};

    always_comb begin
        w_rdata = 32'd0;
        case (r_addr_q)
            A_CTRL:     w_rdata = {29'd0, r_mode, r_en};
            A_PATTERN:  w_rdata = 32'(r_pattern);
            A_PRESCALE: w_rdata = 32'(r_prescale);
            A_DUTY:     w_rdata = 32'(r_duty);
            A_STATUS:   w_rdata = w_status;
            default:    w_rdata = 32'd0;
        endcase
    end

    assign bus.HRDATA    = w_rdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;

    assign w_unused = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0],
                        bus.HSIZE, bus.HPROT, bus.HWDATA};

endmodule

// File: tb/tb_ahblite_led_ctrl.sv
// Bench for ahblite_led_ctrl: closed-form timing model of the LED outputs checked every
// cycle, plus directed bus sequences with literal expectations.
module tb_ahblite_led_ctrl;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic [7:0] LED;

    ahblite_led_ctrl_if bus();

    ahblite_led_ctrl #(
        .NUM_LED(8), .PWM_BITS(8), .PRE_BITS(16), .RST_PRESCALE(32'd999)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .bus(bus),
        .LED(LED)
    );

    always #5 HCLK = ~HCLK;

    int     n_chk = 0;
    int     n_pass = 0;
    longint cyc = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Model: register contents plus the edge at which the timebase last restarted.
    // Counter values are derived from elapsed cycles rather than simulated step by step.
    bit [2:0]   m_ctrl = 3'd0;
    bit [7:0]   m_pat  = 8'd0;
    bit [15:0]  m_pre  = 16'd999;
    bit [7:0]   m_duty = 8'd0;
    longint     m_c    = 0;
    longint     m_pb   = 0;
    logic [7:0] exp_next = 8'd0;
    bit         chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic longint ticks(longint k);
        return (k - m_c) / (longint'(m_pre) + 1);
    endfunction

    function automatic longint wraps(longint k);
        return ticks(k) / 256;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] p, longint n);
        int s;
        logic [15:0] d;
        s = int'(n % 8);
        d = {p, p} << s;
        return d[15:8];
    endfunction

    function automatic logic [7:0] cur_pat(longint k);
        if (m_ctrl[2:1] == 2'd2) return rotl(m_pat, wraps(k) - wraps(m_pb));
        return m_pat;
    endfunction

    function automatic bit phase_at(longint k);
        if (m_ctrl[2:1] == 2'd3) return bit'(wraps(k) % 2);
        return 1'b0;
    endfunction

    // LED value that will appear after edge k+1, given register state after edge k.
    function automatic logic [7:0] led_next(longint k);
        if (!m_ctrl[0]) return 8'h00;
        case (m_ctrl[2:1])
            2'd0:    return m_pat;
            2'd1:    return ((ticks(k) % 256) < longint'(m_duty)) ? m_pat : 8'h00;
            2'd2:    return cur_pat(k);
            default: return phase_at(k) ? m_pat : 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] model_read(logic [2:0] a);
        case (a)
            3'd0:    return {29'd0, m_ctrl};
            3'd1:    return {24'd0, cur_pat(cyc)};
            3'd2:    return {16'd0, m_pre};
            3'd3:    return {24'd0, m_duty};
            3'd4:    return {15'd0, phase_at(cyc), 8'd0, exp_next};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_write(input logic [2:0] a, input logic [31:0] d);
        case (a)
            3'd0: begin
                m_pat  = cur_pat(cyc);
                m_ctrl = d[2:0];
                m_c    = cyc;
                m_pb   = cyc;
            end
            3'd1: begin
                m_pat = d[7:0];
                m_pb  = cyc;
            end
            3'd2: m_pre  = d[15:0];
            3'd3: m_duty = d[7:0];
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_ctrl = 3'd0; m_pat = 8'd0; m_pre = 16'd999; m_duty = 8'd0;
        m_c = cyc; m_pb = cyc;
        exp_next = 8'd0;
    endtask

    always @(negedge HCLK) begin
        if (chk_en) begin
            chk("led", {24'd0, LED}, {24'd0, exp_next});
            chk("hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
            chk("hresp", {31'd0, bus.HRESP}, 32'd0);
        end
        exp_next = led_next(cyc);
    end

    task automatic idle();
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    endtask

    task automatic addr_ph(input logic [2:0] a, input logic wr);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = wr;
        bus.HADDR = {27'd0, a, 2'b00};
    endtask

    // Commits on the second rising edge after the call.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr_ph(a, 1'b1);
        @(posedge HCLK); #1;
        idle();
        bus.HWDATA = d;
        @(posedge HCLK); #1;
        model_write(a, d);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        addr_ph(a, 1'b0);
        @(posedge HCLK); #1;
        idle();
        #3;
        v = bus.HRDATA;
        chk("rd_model", v, model_read(a));
    endtask

    task automatic wait_until(input longint t);
        while (cyc < t) @(negedge HCLK);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        longint      c;
        int          cnt;

        idle();
        bus.HADDR = 32'd0; bus.HWDATA = 32'd0; bus.HREADY = 1'b1;
        bus.HSIZE = 3'b010; bus.HPROT = 4'b0011;

        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        model_reset();
        chk_en = 1'b1;

        // reset state
        chk("rst_led", {24'd0, LED}, 32'd0);
        rd(3'd0, v); chk("rst_ctrl", v, 32'd0);
        rd(3'd1, v); chk("rst_pattern", v, 32'd0);
        rd(3'd2, v); chk("rst_prescale", v, 32'd999);
        rd(3'd3, v); chk("rst_duty", v, 32'd0);
        rd(3'd4, v); chk("rst_status", v, 32'd0);

        // unmapped offsets ignore writes and read zero
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, v); chk("unmapped_5", v, 32'd0);
        rd(3'd7, v); chk("unmapped_7", v, 32'd0);

        // static
        wr(3'd1, 32'h0000_00A5);
        wr(3'd0, 32'h1);
        c = cyc;
        chk("static_before", {24'd0, LED}, 32'd0);
        wait_until(c + 1);
        chk("static_on", {24'd0, LED}, 32'hA5);
        wr(3'd0, 32'h0);
        c = cyc;
        wait_until(c + 1);
        chk("static_off", {24'd0, LED}, 32'd0);

        // PWM, prescale 0, 64/256 duty
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd64);
        wr(3'd1, 32'hFF);
        wr(3'd0, 32'h3);
        c = cyc;
        wait_until(c + 1);
        for (int p = 0; p < 2; p++) begin
            cnt = 0;
            for (int i = 0; i < 256; i++) begin
                if (LED == 8'hFF) cnt++;
                @(negedge HCLK);
            end
            chk("pwm_on_cycles", 32'(cnt), 32'd64);
        end
        wr(3'd3, 32'd0);
        c = cyc;
        wait_until(c + 1);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (LED != 8'h00) cnt++;
            @(negedge HCLK);
        end
        chk("pwm_duty0_on_cycles", 32'(cnt), 32'd0);
        wr(3'd0, 32'h0);

        // rotate, including a PATTERN write landing on a wrap edge
        wr(3'd1, 32'h81);
        wr(3'd0, 32'h5);
        c = cyc;
        wait_until(c + 256); chk("rot_81", {24'd0, LED}, 32'h81);
        wait_until(c + 257); chk("rot_03", {24'd0, LED}, 32'h03);
        wait_until(c + 513); chk("rot_06", {24'd0, LED}, 32'h06);
        wait_until(c + 766);
        wr(3'd1, 32'h11);
        wait_until(c + 769); chk("rot_write_wins", {24'd0, LED}, 32'h11);
        wait_until(c + 1024); chk("rot_hold_11", {24'd0, LED}, 32'h11);
        wait_until(c + 1025); chk("rot_22", {24'd0, LED}, 32'h22);
        rd(3'd1, v); chk("rot_pattern_reg", v, 32'h22);
        wr(3'd0, 32'h0);

        // blink, prescale 1 -> 512-cycle half period
        wr(3'd2, 32'd1);
        wr(3'd1, 32'h0F);
        wr(3'd0, 32'h7);
        c = cyc;
        wait_until(c + 512); chk("blink_off", {24'd0, LED}, 32'h00);
        wait_until(c + 513); chk("blink_on", {24'd0, LED}, 32'h0F);
        wait_until(c + 599);
        rd(3'd4, v); chk("status_phase1", v, 32'h0001_000F);
        wait_until(c + 1024); chk("blink_on_end", {24'd0, LED}, 32'h0F);
        wait_until(c + 1025); chk("blink_off_again", {24'd0, LED}, 32'h00);
        wait_until(c + 1099);
        rd(3'd4, v); chk("status_phase0", v, 32'h0000_0000);

        // back-to-back write then read of PATTERN
        addr_ph(3'd1, 1'b1);
        @(posedge HCLK); #1;
        bus.HWDATA = 32'h0000_003C;
        addr_ph(3'd1, 1'b0);
        @(posedge HCLK); #1;
        model_write(3'd1, 32'h0000_003C);
        idle();
        #3;
        v = bus.HRDATA;
        chk("b2b_model", v, model_read(3'd1));
        chk("b2b_pattern", v, 32'h0000_003C);

        // reset during a write data phase discards the write
        addr_ph(3'd1, 1'b1);
        @(posedge HCLK); #1;
        bus.HWDATA = 32'h0000_0077;
        idle();
        HRESETn = 1'b0;
        chk_en = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        model_reset();
        chk_en = 1'b1;
        chk("mid_rst_led", {24'd0, LED}, 32'd0);
        rd(3'd0, v); chk("mid_rst_ctrl", v, 32'd0);
        rd(3'd1, v); chk("mid_rst_pattern", v, 32'd0);
        rd(3'd2, v); chk("mid_rst_prescale", v, 32'd999);
        rd(3'd3, v); chk("mid_rst_duty", v, 32'd0);
        rd(3'd4, v); chk("mid_rst_status", v, 32'd0);
        repeat (4) @(negedge HCLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
